// File: rtl/hazard_ctrl_if.sv
// Pipeline-control bundle between the core datapath and the hazard sequencer.
// slave  : the sequencer's view (hazard inputs in, stall/flush controls out)
// master : the datapath's view
interface hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // hazard sources
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             halt_req;
    // per-stage controls
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_stall;
    logic             id_ex_flush;
    logic             ex_mem_stall;
    logic             mem_wb_flush;
    // status
    logic             halted;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, mem_ready, halt_req,
        output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, halted, mem_err, stall_cnt, flush_cnt
    );

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, mem_req, mem_ready, halt_req,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
               ex_mem_stall, mem_wb_flush, halted, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32 core: per-stage stall/flush
// generation, debug-halt drain FSM, memory-timeout flag and perf counters.
module hazard_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 1024
) (
    input  logic           clk,
    input  logic           rst,    // active-low, asynchronous
    hazard_ctrl_if.slave   bus
);
    localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int WAIT_W  = (MEM_TIMEOUT  < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q,  wait_cnt_d;
    logic               mem_err_q,   mem_err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic load_use;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic id_ex_flush, ex_mem_stall, mem_wb_flush;

    assign mem_busy = bus.mem_req & ~bus.mem_ready;
    assign load_use = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    // State register: FSM, drain/wait counters, sticky error and perf counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic: halt is only accepted once no redirect or memory wait
    // is pending; a dropped halt_req aborts the drain since ID is being held.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.halt_req && !bus.ex_redirect && !mem_busy) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!bus.halt_req) begin
                    state_d     = ST_RUN;
                    drain_cnt_d = '0;
                end else if (!mem_busy) begin
                    if (drain_cnt_q == DRAIN_ONE) begin
                        state_d     = ST_HALTED;
                        drain_cnt_d = '0;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_ONE;
                    end
                end
            end
            ST_HALTED: begin
                if (!bus.halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d     = ST_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Next-value logic for the timeout watchdog and saturating perf counters
    always_comb begin
        wait_cnt_d = '0;
        if (mem_busy) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
        end
        mem_err_d = mem_err_q | (wait_cnt_d == WAIT_MAX);

        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_RUN) && pc_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        flush_cnt_d = flush_cnt_q;
        if ((state_q == ST_RUN) && bus.ex_redirect && !mem_busy && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Output logic: zero-latency controls, priority mem_busy > state > redirect
    // > load_use; everything is held at zero while reset is asserted.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            if (mem_busy) begin
                // freeze everything up to MEM, bubble into WB
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (state_q != ST_RUN) begin
                // keep the ID instruction parked so it runs on resume
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else if (bus.ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    assign bus.pc_stall     = pc_stall;
    assign bus.if_id_stall  = if_id_stall;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_stall  = id_ex_stall;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.ex_mem_stall = ex_mem_stall;
    assign bus.mem_wb_flush = mem_wb_flush;
    assign bus.halted       = (state_q == ST_HALTED);
    assign bus.mem_err      = mem_err_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Instance A uses default parameters; instance
// B (MEM_TIMEOUT=3, CNT_W=2) covers the timeout flag and counter saturation.
module tb_hazard_ctrl;
    logic clk;
    logic rst;

    hazard_ctrl_if #(.CNT_W(32)) bus_a ();
    hazard_ctrl_if #(.CNT_W(2))  bus_b ();

    hazard_ctrl #(.CNT_W(32), .DRAIN_CYCLES(3), .MEM_TIMEOUT(1024)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    hazard_ctrl #(.CNT_W(2), .DRAIN_CYCLES(3), .MEM_TIMEOUT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    // control vector order: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    // id_ex_flush, ex_mem_stall, mem_wb_flush
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_HOLD = 7'b1100100;
    localparam logic [6:0] C_RD   = 7'b0010100;
    localparam logic [6:0] C_BUSY = 7'b1101011;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic        halted;
        logic        merr;
        logic [31:0] sc;
        logic [31:0] fc;
        logic        merr_b;
        logic [1:0]  sc_b;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic       exp_merr_b = 1'b0;
    logic [1:0] exp_sc_b   = 2'd0;

    logic [6:0] act_ctrl;
    assign act_ctrl = {bus_a.pc_stall, bus_a.if_id_stall, bus_a.if_id_flush,
                       bus_a.id_ex_stall, bus_a.id_ex_flush, bus_a.ex_mem_stall,
                       bus_a.mem_wb_flush};

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mrd, input logic redir, input logic mreq,
                          input logic mrdy, input logic halt);
        bus_a.id_rs1      = rs1;
        bus_a.id_rs2      = rs2;
        bus_a.id_use_rs1  = u1;
        bus_a.id_use_rs2  = u2;
        bus_a.ex_rd       = rd;
        bus_a.ex_mem_read = mrd;
        bus_a.ex_redirect = redir;
        bus_a.mem_req     = mreq;
        bus_a.mem_ready   = mrdy;
        bus_a.halt_req    = halt;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Push the expectation for this cycle, let inputs settle, pop and compare,
    // then advance to the next falling edge.
    task automatic apply(input string tag, input logic [6:0] c, input logic h,
                         input logic e, input int sc, input int fc);
        exp_t x;
        x.ctrl   = c;
        x.halted = h;
        x.merr   = e;
        x.sc     = 32'(sc);
        x.fc     = 32'(fc);
        x.merr_b = exp_merr_b;
        x.sc_b   = exp_sc_b;
        sb_q.push_back(x);
        #1;
        x = sb_q.pop_front();
        n_vec++;
        $display("vec %0d %s: ctrl=%b halted=%b mem_err=%b stall_cnt=%0d flush_cnt=%0d | B mem_err=%b stall_cnt=%0d",
                 n_vec, tag, act_ctrl, bus_a.halted, bus_a.mem_err, bus_a.stall_cnt,
                 bus_a.flush_cnt, bus_b.mem_err, bus_b.stall_cnt);
        assert (act_ctrl === x.ctrl) else begin
            n_err++; $error("FAIL %s ctrl got %b want %b", tag, act_ctrl, x.ctrl);
        end
        assert (bus_a.halted === x.halted) else begin
            n_err++; $error("FAIL %s halted got %b want %b", tag, bus_a.halted, x.halted);
        end
        assert (bus_a.mem_err === x.merr) else begin
            n_err++; $error("FAIL %s mem_err got %b want %b", tag, bus_a.mem_err, x.merr);
        end
        assert (bus_a.stall_cnt === x.sc) else begin
            n_err++; $error("FAIL %s stall_cnt got %0d want %0d", tag, bus_a.stall_cnt, x.sc);
        end
        assert (bus_a.flush_cnt === x.fc) else begin
            n_err++; $error("FAIL %s flush_cnt got %0d want %0d", tag, bus_a.flush_cnt, x.fc);
        end
        assert (bus_b.mem_err === x.merr_b) else begin
            n_err++; $error("FAIL %s b_mem_err got %b want %b", tag, bus_b.mem_err, x.merr_b);
        end
        assert (bus_b.stall_cnt === x.sc_b) else begin
            n_err++; $error("FAIL %s b_stall_cnt got %0d want %0d", tag, bus_b.stall_cnt, x.sc_b);
        end
        @(negedge clk);
    endtask

    // Assert reset between clock edges, check everything is zero, release on
    // the next falling edge.
    task automatic do_reset(input string tag);
        exp_merr_b = 1'b0;
        exp_sc_b   = 2'd0;
        #2;
        rst = 1'b0;
        apply(tag, C_NONE, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        bus_b.id_rs1 = 5'd0; bus_b.id_rs2 = 5'd0;
        bus_b.id_use_rs1 = 1'b0; bus_b.id_use_rs2 = 1'b0;
        bus_b.ex_rd = 5'd0; bus_b.ex_mem_read = 1'b0; bus_b.ex_redirect = 1'b0;
        bus_b.mem_req = 1'b0; bus_b.mem_ready = 1'b0; bus_b.halt_req = 1'b0;

        // Reset held with a load-use pattern on the inputs: outputs forced 0
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("rst_hold", C_NONE, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        idle();

        // 1. Load-use
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("lu_rs1", C_LU, 1'b0, 1'b0, 0, 0);
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("lu_rd0", C_NONE, 1'b0, 1'b0, 1, 0);
        set_in(5'd5, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("lu_rs2", C_LU, 1'b0, 1'b0, 1, 0);
        set_in(5'd5, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("lu_nouse", C_NONE, 1'b0, 1'b0, 2, 0);
        idle();
        do_reset("reset1");

        // 2. Redirect wins over load-use
        set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("rd_lu", C_RD, 1'b0, 1'b0, 0, 0);
        idle();
        apply("rd_after", C_NONE, 1'b0, 1'b0, 0, 1);

        // 3. Memory wait, 4 busy cycles
        for (int i = 0; i < 4; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            apply("mem_busy", C_BUSY, 1'b0, 1'b0, i, 1);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply("mem_done", C_NONE, 1'b0, 1'b0, 4, 1);
        idle();
        apply("mem_idle", C_NONE, 1'b0, 1'b0, 4, 1);
        // redirect during a freeze is deferred until the access completes
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        apply("rd_busy", C_BUSY, 1'b0, 1'b0, 4, 1);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        apply("rd_release", C_RD, 1'b0, 1'b0, 5, 1);
        idle();
        apply("rd_rel_idle", C_NONE, 1'b0, 1'b0, 5, 2);

        // 3b. Timeout on instance B (MEM_TIMEOUT=3, 2-bit counters saturate)
        bus_b.mem_req = 1'b1; bus_b.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_sc_b   = 2'(i);
            exp_merr_b = (i >= 3);
            apply("tmo_busy", C_NONE, 1'b0, 1'b0, 5, 2);
        end
        bus_b.mem_ready = 1'b1;
        exp_sc_b = 2'd3; exp_merr_b = 1'b1;
        apply("tmo_release", C_NONE, 1'b0, 1'b0, 5, 2);
        bus_b.mem_req = 1'b0; bus_b.mem_ready = 1'b0;
        apply("tmo_sticky", C_NONE, 1'b0, 1'b0, 5, 2);
        do_reset("reset2");

        // 4a. Halt drain, no busy
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply("halt_c0", C_NONE, 1'b0, 1'b0, 0, 0);
        for (int i = 1; i <= 3; i++) apply("drain", C_HOLD, 1'b0, 1'b0, 0, 0);
        apply("halted_c4", C_HOLD, 1'b1, 1'b0, 0, 0);
        idle();
        apply("unhalt", C_HOLD, 1'b1, 1'b0, 0, 0);
        apply("run_again", C_NONE, 1'b0, 1'b0, 0, 0);

        // nonzero counters before the second halt
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("pre_lu", C_LU, 1'b0, 1'b0, 0, 0);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("pre_rd", C_RD, 1'b0, 1'b0, 1, 0);

        // 4b. Halt drain with a busy cycle at cycle 2
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        apply("halt2_c0", C_NONE, 1'b0, 1'b0, 1, 1);
        apply("drain2_c1", C_HOLD, 1'b0, 1'b0, 1, 1);
        bus_a.mem_req = 1'b1;
        apply("drain2_busy", C_BUSY, 1'b0, 1'b0, 1, 1);
        bus_a.mem_req = 1'b0;
        apply("drain2_c3", C_HOLD, 1'b0, 1'b0, 1, 1);
        apply("drain2_c4", C_HOLD, 1'b0, 1'b0, 1, 1);
        apply("halted2_c5", C_HOLD, 1'b1, 1'b0, 1, 1);
        apply("halted2_c6", C_HOLD, 1'b1, 1'b0, 1, 1);

        // 6. Async reset mid-HALTED, halt_req and load-use still driven
        set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset("rst_halted");
        idle();
        apply("rst_rel_run", C_NONE, 1'b0, 1'b0, 0, 0);

        // 5. Halt together with redirect
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        apply("hr_c0", C_RD, 1'b0, 1'b0, 0, 0);
        bus_a.ex_redirect = 1'b0;
        apply("hr_c1", C_NONE, 1'b0, 1'b0, 0, 1);
        apply("hr_c2", C_HOLD, 1'b0, 1'b0, 0, 1);
        bus_a.halt_req = 1'b0;
        apply("hr_abort", C_HOLD, 1'b0, 1'b0, 0, 1);
        apply("hr_run", C_NONE, 1'b0, 1'b0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
